// File: rtl/thermal_gov_pkg.sv
// Shared types, default thresholds and fan-curve constants for the thermal governor.
package thermal_gov_pkg;

  typedef enum logic [2:0] {
    GOV_IDLE      = 3'd0,
    GOV_RAMP_UP   = 3'd1,
    GOV_RUN       = 3'd2,
    GOV_RAMP_DOWN = 3'd3,
    GOV_HOLD      = 3'd4,
    GOV_SHUTDOWN  = 3'd5
  } gov_state_t;

  localparam int DEF_SAMPLE_PERIOD = 256;
  localparam int DEF_MAX_LEVEL     = 15;
  localparam int DEF_T_HIGH        = 110;
  localparam int DEF_T_LOW         = 95;
  localparam int DEF_T_CRIT        = 125;
  localparam int DEF_T_RESUME      = 85;
  localparam int DEF_HOLD_SAMPLES  = 4;

  localparam int FAN_MIN    = 64;
  localparam int FAN_MAX    = 255;
  localparam int FAN_OFFSET = 40;
  localparam int FAN_GAIN   = 4;

  // Linear fan curve above FAN_OFFSET, clamped to [FAN_MIN, FAN_MAX]; 10 bits covers 215*4.
  function automatic logic [7:0] fan_duty_calc(input logic [7:0] temp);
    logic [9:0] raw;
    if (temp < 8'(FAN_OFFSET)) return 8'(FAN_MIN);
    raw = 10'(temp - 8'(FAN_OFFSET)) * 10'(FAN_GAIN);
    if (raw < 10'(FAN_MIN)) return 8'(FAN_MIN);
    if (raw > 10'(FAN_MAX)) return 8'(FAN_MAX);
    return raw[7:0];
  endfunction

endpackage

// File: rtl/gov_sample_timer.sv
// Evaluation prescaler: counts 0..PERIOD-1 while run, flags eval at terminal count.
module gov_sample_timer #(
  parameter int PERIOD = 256
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic eval
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] TC = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run)   cnt <= (cnt == TC) ? '0 : cnt + CW'(1);
  end

  // eval still fires on the cycle run drops so a critical sample is never lost
  assign eval = (cnt == TC);

endmodule

// File: rtl/thermal_governor.sv
// DVFS / fan governor: periodic evaluation of thermal and power inputs drives
// frequency level stepping with hysteresis, fan duty and latched thermal shutdown.
//
// state     | meaning
// IDLE      | cores off, level 0, waiting for enable
// RAMP_UP   | +1 level per eval until MAX_LEVEL
// RUN       | at MAX_LEVEL, watching for hot
// RAMP_DOWN | -1 level per eval until a cool sample
// HOLD      | counting cool-ish samples before re-ramping
// SHUTDOWN  | critical temperature, cores off, fan full, waits for T_RESUME
module thermal_governor
  import thermal_gov_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int MAX_LEVEL     = DEF_MAX_LEVEL,
  parameter int T_HIGH        = DEF_T_HIGH,
  parameter int T_LOW         = DEF_T_LOW,
  parameter int T_CRIT        = DEF_T_CRIT,
  parameter int T_RESUME      = DEF_T_RESUME,
  parameter int HOLD_SAMPLES  = DEF_HOLD_SAMPLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  temperature,
  input  logic        throttle_request,
  input  logic [15:0] power_consumption,
  input  logic [15:0] power_cap,
  output logic [3:0]  freq_level,
  output logic        freq_update,
  output logic [7:0]  fan_duty,
  output logic        hash_enable,
  output logic [2:0]  gov_state,
  output logic        fault
);

  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam logic [3:0] MAXL = 4'(MAX_LEVEL);

  gov_state_t state, state_nxt;
  logic [3:0]    level_nxt;
  logic [7:0]    fan_nxt;
  logic          hash_nxt, fault_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt, hold_inc;
  logic          eval, run, hot, cool, crit;

  assign run  = enable || (state == GOV_SHUTDOWN);
  assign hot  = (temperature >= 8'(T_HIGH)) || throttle_request ||
                (power_consumption > power_cap);
  assign cool = (temperature < 8'(T_LOW)) && !throttle_request &&
                (power_consumption <= power_cap);
  assign crit = temperature >= 8'(T_CRIT);
  assign hold_inc = hold_cnt + HW'(1);

  gov_sample_timer #(.PERIOD(SAMPLE_PERIOD)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!run),
    .run     (run),
    .eval    (eval)
  );

  always_comb begin
    state_nxt = state;
    level_nxt = freq_level;
    hold_nxt  = hold_cnt;
    fan_nxt   = fan_duty;
    hash_nxt  = hash_enable;
    fault_nxt = fault;
    if (eval && crit) begin
      state_nxt = GOV_SHUTDOWN;
      level_nxt = '0;
      hash_nxt  = 1'b0;
      fan_nxt   = 8'(FAN_MAX);
      fault_nxt = 1'b1;
    end else if (state == GOV_SHUTDOWN) begin
      if (eval && (temperature <= 8'(T_RESUME))) state_nxt = GOV_IDLE;
    end else if (!enable) begin
      state_nxt = GOV_IDLE;
      level_nxt = '0;
      hash_nxt  = 1'b0;
    end else begin
      if (eval) fan_nxt = fan_duty_calc(temperature);
      unique case (state)
        GOV_IDLE: begin
          state_nxt = GOV_RAMP_UP;
          hash_nxt  = 1'b1;
        end
        GOV_RAMP_UP: if (eval) begin
          if (hot) state_nxt = GOV_RAMP_DOWN;
          else begin
            if (freq_level < MAXL) level_nxt = freq_level + 4'd1;
            if (freq_level >= MAXL - 4'd1) state_nxt = GOV_RUN;
          end
        end
        GOV_RUN: if (eval && hot) state_nxt = GOV_RAMP_DOWN;
        GOV_RAMP_DOWN: if (eval) begin
          if (cool) begin
            state_nxt = GOV_HOLD;
            hold_nxt  = '0;
          end else if (freq_level != 4'd0) begin
            level_nxt = freq_level - 4'd1;
          end
        end
        GOV_HOLD: if (eval) begin
          if (hot) state_nxt = GOV_RAMP_DOWN;
          else begin
            hold_nxt = hold_inc;
            if (hold_inc >= HW'(HOLD_SAMPLES)) state_nxt = GOV_RAMP_UP;
          end
        end
        default: state_nxt = GOV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= GOV_IDLE;
      freq_level  <= '0;
      freq_update <= 1'b0;
      fan_duty    <= 8'(FAN_MAX);
      hash_enable <= 1'b0;
      fault       <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      freq_level  <= level_nxt;
      freq_update <= (level_nxt != freq_level);
      fan_duty    <= fan_nxt;
      hash_enable <= hash_nxt;
      fault       <= fault_nxt;
      hold_cnt    <= hold_nxt;
    end
  end

  assign gov_state = state;

endmodule

// File: tb/tb_thermal_governor.sv
// Randomized and directed bench for thermal_governor against a behavioural model.
module tb_thermal_governor;

  localparam int P    = 8;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  temperature = 8'd70;
  logic        throttle_request = 1'b0;
  logic [15:0] power_consumption = 16'd5000;
  logic [15:0] power_cap = 16'd20000;
  logic [3:0]  freq_level;
  logic        freq_update;
  logic [7:0]  fan_duty;
  logic        hash_enable;
  logic [2:0]  gov_state;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;

  int m_state, m_level, m_fan, m_hash, m_fault, m_upd, m_cnt, m_hold;
  bit m_last_ev;

  thermal_governor #(.SAMPLE_PERIOD(P), .HOLD_SAMPLES(HOLD)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .temperature       (temperature),
    .throttle_request  (throttle_request),
    .power_consumption (power_consumption),
    .power_cap         (power_cap),
    .freq_level        (freq_level),
    .freq_update       (freq_update),
    .fan_duty          (fan_duty),
    .hash_enable       (hash_enable),
    .gov_state         (gov_state),
    .fault             (fault)
  );

  always #5 clk = ~clk;

  wire [17:0] dut_vec = {freq_level, freq_update, fan_duty, hash_enable, gov_state, fault};

  function automatic logic [17:0] exp_vec();
    return {4'(m_level), 1'(m_upd), 8'(m_fan), 1'(m_hash), 3'(m_state), 1'(m_fault)};
  endfunction

  function automatic int fan_ref(input int t);
    int v;
    if (t < 40) return 64;
    v = (t - 40) * 4;
    if (v < 64) v = 64;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_level = 0; m_fan = 255; m_hash = 0; m_fault = 0;
    m_upd = 0; m_cnt = 0; m_hold = 0; m_last_ev = 0;
  endtask

  // Applies the governor rules for one clock edge using the current inputs.
  task automatic model_update();
    bit ev, hot, cool, run;
    int t, old_level;
    t = int'(temperature);
    ev = (m_cnt == P - 1);
    run = enable || (m_state == 5);
    hot = (t >= 110) || throttle_request || (power_consumption > power_cap);
    cool = (t < 95) && !throttle_request && (power_consumption <= power_cap);
    old_level = m_level;
    if (ev && t >= 125) begin
      m_state = 5; m_level = 0; m_hash = 0; m_fan = 255; m_fault = 1;
    end else if (m_state == 5) begin
      if (ev && t <= 85) m_state = 0;
    end else if (!enable) begin
      m_state = 0; m_level = 0; m_hash = 0;
    end else begin
      if (ev) m_fan = fan_ref(t);
      if (m_state == 0) begin
        m_state = 1; m_hash = 1;
      end else if (ev) begin
        case (m_state)
          1: if (hot) m_state = 3;
             else begin
               if (m_level < 15) m_level++;
               if (m_level == 15) m_state = 2;
             end
          2: if (hot) m_state = 3;
          3: if (cool) begin m_state = 4; m_hold = 0; end
             else if (m_level > 0) m_level--;
          4: if (hot) m_state = 3;
             else begin
               m_hold++;
               if (m_hold >= HOLD) m_state = 1;
             end
          default: ;
        endcase
      end
    end
    m_upd = (m_level != old_level);
    m_cnt = !run ? 0 : (m_cnt + 1) % P;
    m_last_ev = ev;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (freq_update) upd_seen++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0; temperature = 8'd70; throttle_request = 1'b0;
    power_consumption = 16'd5000; power_cap = 16'd20000;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    upd_seen = 0;
  endtask

  task automatic wait_evals(input int n);
    int k = 0, guard = 0;
    while (k < n) begin
      step();
      if (m_last_ev) k++;
      guard++;
      if (guard > n * P + 2 * P) begin
        $display("FAIL wait_evals timeout: got %0d evals, required %0d", k, n);
        $fatal(1);
      end
    end
  endtask

  task automatic wait_pre_eval();
    int guard = 0;
    while (m_cnt != P - 1) begin
      step();
      guard++;
      if (guard > 2 * P) begin
        $display("FAIL wait_pre_eval timeout: counter %0d, required %0d", m_cnt, P - 1);
        $fatal(1);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== {4'd0, 1'b0, 8'd255, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got %h required %h", dut_vec, {4'd0, 1'b0, 8'd255, 1'b0, 3'd0, 1'b0});
    end
  endtask

  task automatic test_ramp_up();
    enable = 1'b1;
    step();
    checks++;
    if (hash_enable !== 1'b1 || gov_state !== 3'd1) begin
      errors++;
      $display("FAIL ramp_start: hash_enable=%0b state=%0d required 1/1", hash_enable, gov_state);
    end
    upd_seen = 0;
    wait_evals(15);
    checks++;
    if (upd_seen !== 15 || freq_level !== 4'd15) begin
      errors++;
      $display("FAIL ramp_levels: updates=%0d level=%0d required 15/15", upd_seen, freq_level);
    end
    checks++;
    if (gov_state !== 3'd2 || fan_duty !== 8'd120) begin
      errors++;
      $display("FAIL ramp_run: state=%0d fan=%0d required 2/120", gov_state, fan_duty);
    end
  endtask

  task automatic test_hysteresis();
    temperature = 8'd112;
    wait_evals(1);
    checks++;
    if (gov_state !== 3'd3 || freq_level !== 4'd15) begin
      errors++;
      $display("FAIL hot_enter_down: state=%0d level=%0d required 3/15", gov_state, freq_level);
    end
    wait_evals(2);
    checks++;
    if (freq_level !== 4'd13) begin
      errors++;
      $display("FAIL ramp_down_steps: level=%0d required 13", freq_level);
    end
    temperature = 8'd90;
    wait_evals(1);
    checks++;
    if (gov_state !== 3'd4 || freq_level !== 4'd13) begin
      errors++;
      $display("FAIL enter_hold: state=%0d level=%0d required 4/13", gov_state, freq_level);
    end
    wait_evals(3);
    checks++;
    if (gov_state !== 3'd4) begin
      errors++;
      $display("FAIL hold_stays: state=%0d required 4", gov_state);
    end
    wait_evals(1);
    checks++;
    if (gov_state !== 3'd1 || freq_level !== 4'd13) begin
      errors++;
      $display("FAIL hold_exit: state=%0d level=%0d required 1/13", gov_state, freq_level);
    end
    wait_evals(2);
    checks++;
    if (gov_state !== 3'd2 || freq_level !== 4'd15) begin
      errors++;
      $display("FAIL rerun: state=%0d level=%0d required 2/15", gov_state, freq_level);
    end
  endtask

  task automatic test_power_throttle();
    temperature = 8'd80;
    power_consumption = 16'd21000;
    wait_evals(1);
    checks++;
    if (gov_state !== 3'd3) begin
      errors++;
      $display("FAIL power_hot: state=%0d required 3", gov_state);
    end
    power_consumption = 16'd5000;
    wait_evals(1 + HOLD + 1);
    checks++;
    if (gov_state !== 3'd2 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL power_recover: got %h required %h", dut_vec, exp_vec());
    end
    throttle_request = 1'b1;
    wait_evals(1);
    checks++;
    if (gov_state !== 3'd3 || freq_level !== 4'd15) begin
      errors++;
      $display("FAIL throttle_hot: state=%0d level=%0d required 3/15", gov_state, freq_level);
    end
    throttle_request = 1'b0;
  endtask

  task automatic test_shutdown();
    do_reset();
    enable = 1'b1;
    step();
    wait_evals(3);
    wait_pre_eval();
    temperature = 8'd126;
    enable = 1'b0;
    step();
    checks++;
    if (dut_vec !== {4'd0, 1'b1, 8'd255, 1'b0, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL shutdown_enter: got %h required %h", dut_vec, {4'd0, 1'b1, 8'd255, 1'b0, 3'd5, 1'b1});
    end
    temperature = 8'd90;
    wait_evals(3);
    checks++;
    if (gov_state !== 3'd5 || fault !== 1'b1) begin
      errors++;
      $display("FAIL shutdown_hold: state=%0d fault=%0b required 5/1", gov_state, fault);
    end
    temperature = 8'd85;
    wait_evals(1);
    checks++;
    if (gov_state !== 3'd0 || fault !== 1'b1 || hash_enable !== 1'b0) begin
      errors++;
      $display("FAIL shutdown_exit: state=%0d fault=%0b hash=%0b required 0/1/0", gov_state, fault, hash_enable);
    end
    do_reset();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: fault=%0b required 0", fault);
    end
  endtask

  task automatic test_enable_drop();
    int cyc;
    do_reset();
    enable = 1'b1;
    step();
    wait_evals(6);
    step();
    step();
    enable = 1'b0;
    upd_seen = 0;
    step();
    checks++;
    if (gov_state !== 3'd0 || freq_level !== 4'd0 || freq_update !== 1'b1 || hash_enable !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: state=%0d level=%0d upd=%0b hash=%0b required 0/0/1/0",
               gov_state, freq_level, freq_update, hash_enable);
    end
    repeat (5) step();
    checks++;
    if (upd_seen !== 1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL drop_single_pulse: pulses=%0d vec=%h required 1/%h", upd_seen, dut_vec, exp_vec());
    end
    enable = 1'b1;
    cyc = 0;
    while (freq_level !== 4'd1 && cyc < 3 * P) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc !== P) begin
      errors++;
      $display("FAIL drop_counter_cleared: first level after %0d cycles, required %0d", cyc, P);
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    temperature = 8'd20;
    throttle_request = 1'b1;
    enable = 1'b1;
    step();
    upd_seen = 0;
    wait_evals(1);
    checks++;
    if (fan_duty !== 8'd64 || gov_state !== 3'd3 || freq_level !== 4'd0) begin
      errors++;
      $display("FAIL fan_min_down: fan=%0d state=%0d level=%0d required 64/3/0", fan_duty, gov_state, freq_level);
    end
    wait_evals(2);
    checks++;
    if (freq_level !== 4'd0 || upd_seen !== 0 || gov_state !== 3'd3) begin
      errors++;
      $display("FAIL level_floor: level=%0d pulses=%0d state=%0d required 0/0/3", freq_level, upd_seen, gov_state);
    end
    throttle_request = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 12) temperature = 8'($urandom_range(15, 130));
      if ($urandom_range(0, 99) < 8) power_consumption = 16'($urandom_range(0, 25000));
      if ($urandom_range(0, 99) < 5) throttle_request = ($urandom_range(0, 9) == 0);
      if (enable) begin
        if ($urandom_range(0, 199) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        enable = 1'b1;
      end
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp_up();
    test_hysteresis();
    test_power_throttle();
    test_shutdown();
    test_enable_drop();
    test_boundaries();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thermal_governor.md
Name: thermal_governor

Overview:
Closed-loop DVFS/fan controller that sequences the BM1387 hash datapath against the chip thermal/power model.
- Samples temperature, throttle_request and power_consumption every SAMPLE_PERIOD cycles.
- Steps the core frequency level up or down with hysteresis, and drives fan duty.
- Forces a latched thermal shutdown at critical temperature.
- Sits between the thermal model and the hash-core clock/enable logic.

Parameters:
SAMPLE_PERIOD, 256, clock cycles between evaluations (>=2)
MAX_LEVEL, 15, highest frequency level (4-bit)
T_HIGH, 110, °C; at or above this triggers ramp-down
T_LOW, 95, °C; ramp-down ends below this
T_CRIT, 125, °C; at or above this triggers shutdown
T_RESUME, 85, °C; shutdown exit threshold
HOLD_SAMPLES, 4, cool evaluations required before re-ramping

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  governor/mining enable
temperature  in  8  chip temperature, °C unsigned
throttle_request  in  1  throttle flag from thermal model
power_consumption  in  16  measured power, mW
power_cap  in  16  board power budget, mW
freq_level  out  4  current frequency level, 0..MAX_LEVEL
freq_update  out  1  one-cycle pulse, asserted with every freq_level change
fan_duty  out  8  fan PWM duty, 0..255
hash_enable  out  1  hash cores enabled
gov_state  out  3  encoded FSM state
fault  out  1  sticky critical-temperature flag

Behaviour:
Reset values:
- freq_level=0, freq_update=0, fan_duty=255, hash_enable=0, gov_state=IDLE(0), fault=0.
- Sample counter=0, hold counter=0.

Sample timer:
- Counts 0..SAMPLE_PERIOD-1 while enable=1 or state=SHUTDOWN.
- eval pulses for one cycle at terminal count.
- Counter is held at 0 when enable=0 and state!=SHUTDOWN.

Evaluation definitions:
- hot = (temperature>=T_HIGH) | throttle_request | (power_consumption>power_cap).
- cool = (temperature<T_LOW) & !throttle_request & (power_consumption<=power_cap).
- Inputs are sampled only on eval cycles. All outputs are registered; a decision is visible the cycle after eval.

States:
- IDLE(0): hash_enable=0, freq_level=0. enable=1 -> RAMP_UP next cycle; hash_enable=1 in that cycle.
- RAMP_UP(1), per eval:
  - hot -> RAMP_DOWN, with no increment.
  - otherwise freq_level+1; on reaching MAX_LEVEL -> RUN.
- RUN(2): eval with hot -> RAMP_DOWN.
- RAMP_DOWN(3), per eval:
  - freq_level-1, saturating at 0.
  - If cool at the same eval -> HOLD, hold counter cleared, and no decrement.
- HOLD(4), per eval:
  - hot -> RAMP_DOWN.
  - otherwise hold counter+1; when it reaches HOLD_SAMPLES -> RAMP_UP.
  - Neither cool nor hot: counter still advances.
- SHUTDOWN(5):
  - freq_level=0, hash_enable=0, fan_duty=255, fault=1.
  - Exit to IDLE at an eval with temperature<=T_RESUME.
  - enable is ignored while in SHUTDOWN.

Precedence and overrides:
- Critical: at any eval, temperature>=T_CRIT -> SHUTDOWN. This overrides every other transition, including the enable drop in the same cycle.
- fault is cleared only by reset_n.
- enable falling in any state other than SHUTDOWN: the next cycle goes to IDLE and freq_level becomes 0, with freq_update pulsed if the level was nonzero. An in-flight sample is discarded.

Fan duty:
- Updated at each eval outside SHUTDOWN.
- fan_duty = clamp((temperature-40)*4, 64, 255).
- Compute in 10 bits; temperature<40 gives 64.
- Held between evals.

Width and integrity rules:
- freq_level arithmetic never wraps (saturates at 0 and MAX_LEVEL).
- freq_update is never asserted without a value change.

Decomposition:
- Shared package thermal_gov_pkg:
  - gov_state_t enum (IDLE..SHUTDOWN encodings above).
  - Default thresholds.
  - FAN_MIN=64, FAN_MAX=255, FAN_OFFSET=40, FAN_GAIN=4.
- One sub-module, gov_sample_timer: parameterised prescaler with clear/run inputs and an eval pulse output.
- FSM and fan datapath stay in thermal_governor.

Test Plan (SAMPLE_PERIOD=8, HOLD_SAMPLES=4 for sim):
1. Reset, then enable=1 with temperature=70, cap=20000, power=5000 -> hash_enable=1 after 1 cycle; freq_level steps 1..15 on 15 evals with 15 freq_update pulses; RUN; fan_duty=120.
2. In RUN, set temperature=112 -> RAMP_DOWN at next eval; freq_level 15->14->13. Set temperature=90 -> HOLD, level held; after 4 cool evals -> RAMP_UP.
3. In RUN, set power=21000 with temperature=80 -> RAMP_DOWN. throttle_request=1 alone gives the same result.
4. Set temperature=126 mid-RAMP_UP with enable dropped in the same cycle -> SHUTDOWN, freq_level=0, hash_enable=0, fan_duty=255, fault=1. Temperature=90 gives no exit; temperature=85 -> IDLE with fault still 1; reset_n clears fault.
5. Drop enable mid-RAMP_UP at level 6 -> IDLE next cycle, freq_level=0, single freq_update pulse, counter held at 0.
6. Set temperature=20 at eval -> fan_duty=64. Level at 0 in RAMP_DOWN with hot -> no change and no freq_update.
